// File: rtl/ttw_mem_arb_if.sv
// Walker-request / memory-port signal bundle for ttw_mem_arb.
// The arbiter side uses the master modport; the walkers and memory model use slave.
interface ttw_mem_arb_if #(
   parameter int N_REQ  = 4,
   parameter int IDX_W  = 2,
   parameter int MCN_W  = 40,
   parameter int DATA_W = 512
);
   logic [N_REQ-1:0]       req_i_valid;
   logic [N_REQ-1:0]       req_o_ready;
   logic [N_REQ*MCN_W-1:0] req_i_bits_mcn;
   logic [N_REQ-1:0]       res_o_valid;
   logic [N_REQ-1:0]       res_i_ready;
   logic [DATA_W-1:0]      res_o_bits_data;
   logic                   mem_req_o_valid;
   logic                   mem_req_o_ready;
   logic [IDX_W-1:0]       mem_req_o_bits_idx;
   logic [MCN_W-1:0]       mem_req_o_bits_mcn;
   logic                   mem_res_i_valid;
   logic                   mem_res_i_ready;
   logic [IDX_W-1:0]       mem_res_i_bits_idx;
   logic [DATA_W-1:0]      mem_res_i_bits_data;
   logic                   busy_o;
   logic                   err_o;

   modport master (
      input  req_i_valid, req_i_bits_mcn, res_i_ready, mem_req_o_ready,
             mem_res_i_valid, mem_res_i_bits_idx, mem_res_i_bits_data,
      output req_o_ready, res_o_valid, res_o_bits_data, mem_req_o_valid,
             mem_req_o_bits_idx, mem_req_o_bits_mcn, mem_res_i_ready, busy_o, err_o
   );

   modport slave (
      output req_i_valid, req_i_bits_mcn, res_i_ready, mem_req_o_ready,
             mem_res_i_valid, mem_res_i_bits_idx, mem_res_i_bits_data,
      input  req_o_ready, res_o_valid, res_o_bits_data, mem_req_o_valid,
             mem_req_o_bits_idx, mem_req_o_bits_mcn, mem_res_i_ready, busy_o, err_o
   );
endinterface

// File: rtl/ttw_mem_arb.sv
// Round-robin arbiter of table-walker requesters onto one memory request channel,
// with per-requester outstanding tracking and tag-based response routing.
module ttw_mem_arb #(
   parameter int N_REQ   = 4,
   parameter int IDX_W   = 2,
   parameter int MCN_W   = 40,
   parameter int DATA_W  = 512,
   parameter int MAX_OUT = 2
) (
   input  logic          clock,
   input  logic          reset,
   ttw_mem_arb_if.master bus
);
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic              slot_valid_r;
   logic [IDX_W-1:0]  slot_idx_r;
   logic [MCN_W-1:0]  slot_mcn_r;
   logic [IDX_W-1:0]  ptr_r;
   logic [CNT_W-1:0]  cnt_r [N_REQ];
   logic              err_r;

   logic [N_REQ-1:0]  elig_s;
   logic              slot_free_s;
   logic              found_s;
   logic [IDX_W-1:0]  cand_s;
   logic              gnt_vld_s;
   logic [IDX_W-1:0]  gnt_idx_s;
   logic [MCN_W-1:0]  gnt_mcn_s;
   logic [N_REQ-1:0]  gnt_oh_s;
   logic              res_legal_s;
   logic              res_rdy_s;
   logic              res_stray_s;
   logic [N_REQ-1:0]  res_oh_s;
   logic              any_out_s;

   // Requester eligibility: valid and below its outstanding limit
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig_s[i] = bus.req_i_valid[i] && (int'(cnt_r[i]) < MAX_OUT);
      end
   end

   // Round-robin pick starting at the pointer; grants only into a free slot
   always_comb begin
      slot_free_s = !slot_valid_r || bus.mem_req_o_ready;
      found_s     = 1'b0;
      cand_s      = {IDX_W{1'b0}};
      gnt_idx_s   = {IDX_W{1'b0}};
      for (int off = 0; off < N_REQ; off++) begin
         cand_s = IDX_W'((int'(ptr_r) + off) % N_REQ);
         if (!found_s && elig_s[cand_s]) begin
            found_s   = 1'b1;
            gnt_idx_s = cand_s;
         end else begin
            found_s   = found_s;
         end
      end
      // reset gating keeps req_o_ready low while the block is held in reset
      gnt_vld_s = found_s && slot_free_s && reset;
      gnt_mcn_s = {MCN_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         gnt_oh_s[i] = gnt_vld_s && (gnt_idx_s == IDX_W'(i));
         if (gnt_idx_s == IDX_W'(i)) begin
            gnt_mcn_s = bus.req_i_bits_mcn[i*MCN_W +: MCN_W];
         end else begin
            gnt_mcn_s = gnt_mcn_s;
         end
      end
   end

   // Response steering by tag; responses with no matching outstanding request are drained
   always_comb begin
      if (int'(bus.mem_res_i_bits_idx) < N_REQ) begin
         res_legal_s = (cnt_r[bus.mem_res_i_bits_idx] != {CNT_W{1'b0}});
      end else begin
         res_legal_s = 1'b0;
      end
      if (res_legal_s) begin
         res_rdy_s = reset && bus.res_i_ready[bus.mem_res_i_bits_idx];
      end else begin
         res_rdy_s = reset;
      end
      res_stray_s = reset && bus.mem_res_i_valid && !res_legal_s;
      for (int i = 0; i < N_REQ; i++) begin
         res_oh_s[i] = reset && res_legal_s && bus.mem_res_i_valid &&
                       (bus.mem_res_i_bits_idx == IDX_W'(i));
      end
   end

   // Any requester with a request still in flight
   always_comb begin
      any_out_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         any_out_s = any_out_s || (cnt_r[i] != {CNT_W{1'b0}});
      end
   end

   // Request slot, round-robin pointer and sticky stray-response flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_valid_r <= 1'b0;
         slot_idx_r   <= {IDX_W{1'b0}};
         slot_mcn_r   <= {MCN_W{1'b0}};
         ptr_r        <= {IDX_W{1'b0}};
         err_r        <= 1'b0;
      end else begin
         if (gnt_vld_s) begin
            slot_valid_r <= 1'b1;
            slot_idx_r   <= gnt_idx_s;
            slot_mcn_r   <= gnt_mcn_s;
            ptr_r        <= IDX_W'((int'(gnt_idx_s) + 1) % N_REQ);
         end else if (bus.mem_req_o_ready) begin
            slot_valid_r <= 1'b0;
         end else begin
            slot_valid_r <= slot_valid_r;
         end
         if (res_stray_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   // Outstanding counters: grant increments, response fire decrements, both cancel
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REQ; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            case ({gnt_oh_s[i], res_oh_s[i] && res_rdy_s})
               2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
               2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
               default: cnt_r[i] <= cnt_r[i];
            endcase
         end
      end
   end

   assign bus.req_o_ready        = gnt_oh_s;
   assign bus.res_o_valid        = res_oh_s;
   assign bus.res_o_bits_data    = bus.mem_res_i_bits_data;
   assign bus.mem_req_o_valid    = slot_valid_r;
   assign bus.mem_req_o_bits_idx = slot_idx_r;
   assign bus.mem_req_o_bits_mcn = slot_mcn_r;
   assign bus.mem_res_i_ready    = res_rdy_s;
   assign bus.busy_o             = slot_valid_r || any_out_s;
   assign bus.err_o              = err_r;
endmodule
